// File: rtl/regfile_display_scanner_if.sv
// Debug display port of the register file: the scanner drives the select,
// the register file answers combinationally with the selected word.
interface regfile_display_scanner_if;
  logic [4:0]  displaySelect;
  logic [31:0] displayData;

  modport master (output displaySelect, input  displayData);
  modport slave  (input  displaySelect, output displayData);
endinterface

// File: rtl/regfile_display_scanner.sv
// Register file display scanner: manual/auto selection of a register, shown as
// 2 index digits + 4 value digits. Optional macro: REGFILE_DISPLAY_SKIP_ZERO_EN.

module rds_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

module rds_seg_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1000000;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1000000;
    endcase
  end
endmodule

module regfile_display_scanner #(
  parameter int SCAN_DIV    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               auto_mode,
  input  logic [4:0]                         sw_sel,
  input  logic                               btn_next,
  input  logic                               half_sel,
  input  logic                               freeze,
  regfile_display_scanner_if.master          rf,
  output logic [6:0]                         hex5,
  output logic [6:0]                         hex4,
  output logic [6:0]                         hex3,
  output logic [6:0]                         hex2,
  output logic [6:0]                         hex1,
  output logic [6:0]                         hex0,
  output logic                               half_led
);
  localparam int NUM_DIGITS = 6;
  localparam int CNT_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int ARM_W      = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  typedef enum logic {ST_MANUAL, ST_AUTO} state_e;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic             half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             btn_dly_q, btn_dly_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;

  logic btn_s, auto_s, freeze_s, btn_pulse, arm_done;

  rds_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({btn_next, auto_mode, freeze}),
    .q   ({btn_s, auto_s, freeze_s})
  );

  // The chain comes out of reset at 0, which would look like a fresh press if the
  // button is held; pulses are only armed once a real released level is seen.
  assign arm_done  = (arm_cnt_q == ARM_LAST);
  assign btn_pulse = btn_s & ~btn_dly_q & armed_q;

  function automatic logic [4:0] fix_zero(input logic [4:0] i);
`ifdef REGFILE_DISPLAY_SKIP_ZERO_EN
    return (i == 5'd0) ? 5'd1 : i;
`else
    return i;
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    data_d    = freeze_s ? data_q : rf.displayData;
    btn_dly_d = btn_s;
    arm_cnt_d = arm_done ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
    armed_d   = armed_q | (arm_done & ~btn_s);
    unique case (state_q)
      ST_MANUAL: begin
        cnt_d = '0;
        if (auto_s) begin
          // mode change wins over a coincident button pulse
          state_d = ST_AUTO;
          half_d  = 1'b0;
          idx_d   = fix_zero(idx_q);
        end else begin
          if (btn_pulse) idx_d = fix_zero(sw_sel);
          half_d = half_sel;
        end
      end
      ST_AUTO: begin
        if (!auto_s) begin
          state_d = ST_MANUAL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            idx_d  = fix_zero(idx_q + 5'd1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_MANUAL;
      idx_q     <= '0;
      half_q    <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      btn_dly_q <= 1'b0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      btn_dly_q <= btn_dly_d;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
    end
  end

  assign rf.displaySelect = idx_q;
  assign half_led         = half_q;

  logic [15:0]                      shown;
  logic [NUM_DIGITS-1:0][3:0]       nib;
  logic [NUM_DIGITS-1:0][6:0]       seg;

  assign shown = half_q ? data_q[31:16] : data_q[15:0];
  assign nib   = {{3'b000, idx_q[4]}, idx_q[3:0], shown};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    rds_seg_dec u_dec (.nib(nib[g]), .seg(seg[g]));
  end

  assign {hex5, hex4, hex3, hex2, hex1, hex0} = seg;
endmodule

// File: tb/tb_regfile_display_scanner.sv
// Randomised bench for regfile_display_scanner with a cycle-level behavioural model
// plus directed scenarios (manual step, auto scan order, freeze, coincident events, reset).
module tb_regfile_display_scanner;
  localparam int SD = 4;
  localparam int SS = 2;
  localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 0, rst = 1;
  logic auto_mode = 0, btn_next = 0, half_sel = 0, freeze = 0;
  logic [4:0] sw_sel = 0;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic half_led;
  logic [31:0] regs [32];
  int errors = 0, checks = 0;
  bit chk_en = 0;

  regfile_display_scanner_if ifc ();
  assign ifc.displayData = regs[ifc.displaySelect];

  regfile_display_scanner #(.SCAN_DIV(SD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .auto_mode(auto_mode), .sw_sel(sw_sel), .btn_next(btn_next),
    .half_sel(half_sel), .freeze(freeze), .rf(ifc.master),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .half_led(half_led));

  always #5 clk = ~clk;

  // behavioural model: display position, captured word, raw input history
  int m_idx, m_half, m_cnt;
  bit m_auto;
  logic [31:0] m_data;
  bit hb[$], ha[$], hf[$];

  function automatic logic [6:0] gly(input logic [3:0] n);
    return GLY[n];
  endfunction

  function automatic int skip0(input int i);
`ifdef REGFILE_DISPLAY_SKIP_ZERO_EN
    return (i == 0) ? 1 : i;
`else
    return i;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_half = 0; m_cnt = 0; m_auto = 0; m_data = 0;
    hb.delete(); ha.delete(); hf.delete();
  endtask

  // Called just after each rising edge: applies what that edge did, using the
  // inputs that were stable across it.
  task automatic model_step();
    int n, pos;
    bit as, fs, pl;
    if (rst) return;
    n  = hb.size();
    as = (n >= SS) ? ha[n-SS] : 1'b0;
    fs = (n >= SS) ? hf[n-SS] : 1'b0;
    pl = (n >= SS + 1) && hb[n-SS] && !hb[n-SS-1];
    if (!fs) m_data = regs[m_idx];
    if (!m_auto) begin
      if (as) begin
        m_auto = 1; m_cnt = 0; m_half = 0; m_idx = skip0(m_idx);
      end else begin
        if (pl) m_idx = skip0(int'(sw_sel));
        m_half = int'(half_sel);
      end
    end else if (!as) begin
      m_auto = 0; m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == SD) begin
        m_cnt = 0;
        pos = (m_idx * 2 + m_half + 1) % 64;
        if (skip0(pos / 2) != pos / 2) pos = 2;
        m_idx = pos / 2; m_half = pos % 2;
      end
    end
    hb.push_back(btn_next); ha.push_back(auto_mode); hf.push_back(freeze);
    if (hb.size() > SS + 1) begin void'(hb.pop_front()); void'(ha.pop_front()); void'(hf.pop_front()); end
  endtask

  always @(negedge clk) begin
    logic [15:0] v;
    if (chk_en) begin
      v = m_half ? m_data[31:16] : m_data[15:0];
      chk("sel", 32'(ifc.displaySelect), 32'(m_idx));
      chk("half_led", 32'(half_led), 32'(m_half));
      chk("hex54", {hex5, hex4}, {gly(4'(m_idx >> 4)), gly(4'(m_idx))});
      chk("hex3210", {hex3, hex2, hex1, hex0}, {gly(v[15:12]), gly(v[11:8]), gly(v[7:4]), gly(v[3:0])});
    end
  end

  task automatic tick();
    @(posedge clk); #1; model_step();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_hex"}, {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h40}});
    chk({tag, "_sel"}, 32'(ifc.displaySelect), 0);
    chk({tag, "_led"}, 32'(half_led), 0);
  endtask

  int seq_sel[5], seq_half[5], chg_t[5], chg_s[5], chg_h[5];
  int nchg, prev, cur, t;
  bit found;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 0; regs[5] = 32'hDEADBEEF; regs[7] = 32'h00001234;
    model_reset();
    chk_en = 1;
    repeat (3) tick();
    chk_reset_outs("reset");
    rst = 0;
    repeat (5) tick();
    chk_reset_outs("post_reset");

    // manual step to x5
    sw_sel = 5; btn_next = 1;
    repeat (2) tick();
    chk("sel_before_latency", 32'(ifc.displaySelect), 0);
    tick();
    chk("sel_after_latency", 32'(ifc.displaySelect), 5);
    tick();
    chk("idx_05", {hex5, hex4}, {7'h40, 7'h12});
    chk("val_BEEF", {hex3, hex2, hex1, hex0}, {7'h03, 7'h06, 7'h06, 7'h0E});
    btn_next = 0; half_sel = 1;
    tick();
    chk("val_dEAd", {hex3, hex2, hex1, hex0}, {7'h21, 7'h06, 7'h08, 7'h21});
    chk("half_led_hi", 32'(half_led), 1);

    // auto scan from 30
    tick();
    sw_sel = 30; btn_next = 1; repeat (4) tick(); btn_next = 0; repeat (2) tick();
    seq_sel = '{30, 30, 31, 31, skip0(0)};
    seq_half = '{0, 1, 0, 1, 0};
    prev = {ifc.displaySelect, half_led};
    auto_mode = 1; nchg = 0;
    for (t = 0; t < 60 && nchg < 5; t++) begin
      tick();
      cur = {ifc.displaySelect, half_led};
      if (cur != prev) begin
        chg_t[nchg] = t; chg_s[nchg] = cur >> 1; chg_h[nchg] = cur & 1; nchg++; prev = cur;
      end
    end
    chk("scan_steps_seen", nchg, 5);
    for (int i = 0; i < nchg; i++) begin
      chk("scan_sel", chg_s[i], seq_sel[i]);
      chk("scan_half", chg_h[i], seq_half[i]);
      if (i > 0) chk("scan_gap", chg_t[i] - chg_t[i-1], SD);
    end

    // freeze while x7 is shown
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      found = (ifc.displaySelect == 7) && !half_led;
    end
    chk("reach_x7", found, 1);
    freeze = 1; regs[8] = 32'hFFFFFFFF;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = (ifc.displaySelect == 8);
    end
    chk("reach_x8", found, 1);
    tick();
    chk("frozen_idx_08", {hex5, hex4}, {7'h40, 7'h00});
    chk("frozen_val_1234", {hex3, hex2, hex1, hex0}, {7'h79, 7'h24, 7'h30, 7'h19});
    freeze = 0;

    // button coincident with auto rise
    auto_mode = 0; half_sel = 0;
    repeat (6) tick();
    prev = ifc.displaySelect;
    sw_sel = 5'(prev) ^ 5'h11; btn_next = 1; auto_mode = 1;
    repeat (5) tick();
    chk("coincident_idx", 32'(ifc.displaySelect), prev);
    chk("coincident_half", 32'(half_led), 0);
    btn_next = 0;

    // async reset mid-dwell, held button across release
    repeat (2) tick();
    #2 rst = 1; model_reset();
    #1 chk_reset_outs("async_rst");
    btn_next = 1; auto_mode = 0; sw_sel = 9;
    repeat (2) tick();
    rst = 0;
    repeat (8) tick();
    chk("held_btn_no_pulse", 32'(ifc.displaySelect), 0);
    btn_next = 0;

    // random phase
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 59) == 0) auto_mode = ~auto_mode;
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      if ($urandom_range(0, 3) == 0) half_sel = $urandom;
      if ($urandom_range(0, 3) == 0) sw_sel = $urandom;
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 31)] = $urandom;
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) begin rst = 1; model_reset(); end
    end
    @(posedge clk); #2;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_display_scanner.md
Name: regfile_display_scanner

Overview:
- Reader on the register file's debug display port.
- Drives the 5-bit display select and samples the returned 32-bit word.
- Renders the selected register on six active-low seven-segment digits of the FPGA board: 2 digits for the register index, 4 digits for one 16-bit half of the value.
- Two modes: manual selection from switches with a step button, and timed auto-scan through all 32 registers.

Parameters:
- SCAN_DIV, 50_000_000, clock cycles per dwell period in auto mode (minimum 2).
- SYNC_STAGES, 2, flip-flop stages synchronising btn_next, auto_mode, freeze (minimum 2).

Ports:
- clk  in  1  system clock, same clock as the register file.
- rst  in  1  asynchronous active-high reset.
- auto_mode  in  1  1 = auto-scan, 0 = manual (asynchronous, synchronised internally).
- sw_sel  in  5  register index loaded when btn_next rises in manual mode.
- btn_next  in  1  step button, active-high, asynchronous.
- half_sel  in  1  manual mode: 0 = low half [15:0], 1 = high half [31:16].
- freeze  in  1  1 = hold the captured value (synchronised).
- displaySelect  out  5  register index presented to the register file.
- displayData  in  32  register contents returned combinationally for displaySelect.
- hex5, hex4  out  7 each  register index as two hex digits (0x00–0x1F), segments {g..a}, active-low.
- hex3..hex0  out  7 each  selected 16-bit half, hex3 = most significant nibble.
- half_led  out  1  half currently shown (1 = high).

Behaviour:
- Reset (async, immediate):
  - state = MANUAL, idx = 0, half = 0, dwell counter = 0, data_q = 0, synchronisers cleared.
  - All hex outputs show glyph "0" (7'b1000000).
  - half_led = 0, displaySelect = 0.
- displaySelect is driven directly from registered idx and never glitches between clock edges.
- Data capture:
  - data_q <= displayData every cycle unless freeze_s = 1.
  - Latency from an idx change to the hex outputs is 1 cycle: the segment decode is combinational from data_q and idx.
- Button edge: a rising edge is detected on the synchronised btn_next (btn_s & ~btn_s_d), giving a one-cycle pulse.
- State MANUAL (auto_mode_s = 0):
  - On a button pulse, idx <= sw_sel.
  - half follows half_sel (registered, 1-cycle delay).
  - The dwell counter is held at 0.
- State AUTO (auto_mode_s = 1):
  - The dwell counter increments every cycle.
  - At SCAN_DIV-1 the counter wraps to 0 and the display advances:
    - if half = 0: half <= 1;
    - else: half <= 0 and idx <= idx + 1 (mod 32, 31 wraps to 0).
  - Button pulses are ignored. half_sel is ignored.
- Transitions:
  - MANUAL→AUTO when auto_mode_s rises. Scanning starts from the current idx with half = 0 and counter = 0.
  - AUTO→MANUAL when auto_mode_s falls. idx and half keep their values until the next button pulse or half_sel sample.
- Freeze:
  - data_q is held, but idx keeps advancing in AUTO.
  - The index digits therefore update while the value digits hold. This is intentional, for capturing a transient value.
- Simultaneous events:
  - Button pulse in the same cycle as MANUAL→AUTO: the mode change wins and idx is not loaded.
  - Dwell wrap in the same cycle as AUTO→MANUAL: the transition wins and no advance occurs.
- The segment decoder covers all 16 nibble values, including A–F: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset asserted mid-dwell or mid-button-press returns to the reset state immediately. A button still held at reset release produces no pulse.

Optional Feature:
- Macro: REGFILE_DISPLAY_SKIP_ZERO_EN.
- Defined:
  - Auto-scan idx wraps 31→1, never selecting x0 (hard-wired zero).
  - A manual load of sw_sel = 0 is forced to idx = 1.
  - Entering AUTO with idx = 0 starts at idx = 1.
- Undefined: all indices 0–31 are reachable as described above.

Test Plan:
- Reset, then release with the register model holding x0 = 0: all hex outputs = 7'b1000000, displaySelect = 0, half_led = 0.
- Manual step:
  - Stimulus: model x5 = 0xDEADBEEF, sw_sel = 5, pulse btn_next.
  - With half_sel = 0: displaySelect = 5 after synchroniser delay + 1 cycle, then hex3..hex0 show "BEEF" and hex5/hex4 show "05".
  - Set half_sel = 1: hex outputs show "dEAd" and half_led = 1.
- Auto scan with SCAN_DIV = 4, starting at idx = 30:
  - Sequence: (30,L)→(30,H)→(31,L)→(31,H)→(0,L), each step exactly 4 cycles apart.
  - With REGFILE_DISPLAY_SKIP_ZERO_EN defined, the final step goes to (1,L) instead.
- Freeze in AUTO:
  - Stimulus: assert freeze while x7 = 0x00001234 is shown, change the model so x8 = 0xFFFFFFFF.
  - Required: hex3..hex0 stay "1234" while hex5/hex4 advance to "08".
- Simultaneous events: button pulse coincident with the auto_mode rise → idx unchanged and scanning begins. Async reset mid-dwell → outputs return to reset values before the next clock edge.
